// File: rtl/dvp_frame_scheduler.sv
// Capture sequencer for the DVP RX pixel path: arms on start, aligns to SOF,
// gates the pixel FIFO for one frame per buffer and ping-pongs two buffers.
module dvp_frame_scheduler #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned PXL_CNT_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start_i,
  input  logic                 cfg_single_i,
  input  logic [PXL_CNT_W-1:0] cfg_frame_pxl_i,
  input  logic [ADDR_W-1:0]    cfg_buf0_base_i,
  input  logic [ADDR_W-1:0]    cfg_buf1_base_i,
  input  logic                 sof_i,
  input  logic                 pxl_acc_i,
  input  logic                 wr_idle_i,
  input  logic [1:0]           buf_rel_i,
  output logic                 cap_en_o,
  output logic [ADDR_W-1:0]    pxl_base_addr_o,
  output logic                 buf_sel_o,
  output logic [1:0]           buf_full_o,
  output logic                 frame_done_o,
  output logic                 frame_done_buf_o,
  output logic                 frame_err_o,
  output logic [7:0]           drop_cnt_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SOF = 3'd1,
    S_CAPTURE  = 3'd2,
    S_DRAIN    = 3'd3,
    S_ABORT    = 3'd4
  } state_t;

  state_t               state;
  logic                 next_buf;
  logic [PXL_CNT_W-1:0] pxl_cnt;
  logic [PXL_CNT_W-1:0] frame_size;

  logic       last_pxl;
  logic       pick_ok;
  logic       pick_buf;
  logic [1:0] buf_set;

  assign state_o  = state;
  assign last_pxl = pxl_acc_i && (pxl_cnt == frame_size - PXL_CNT_W'(1));

  // Buffer choice at SOF: preferred ping-pong buffer, else the other, else drop.
  always_comb begin
    pick_ok  = 1'b1;
    pick_buf = next_buf;
    if (buf_full_o[next_buf]) begin
      if (!buf_full_o[~next_buf]) pick_buf = ~next_buf;
      else                        pick_ok  = 1'b0;
    end
  end

  always_comb begin
    buf_set = 2'b00;
    if (state == S_DRAIN && wr_idle_i) buf_set[buf_sel_o] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      next_buf         <= 1'b0;
      pxl_cnt          <= '0;
      frame_size       <= '0;
      cap_en_o         <= 1'b0;
      pxl_base_addr_o  <= '0;
      buf_sel_o        <= 1'b0;
      buf_full_o       <= 2'b00;
      frame_done_o     <= 1'b0;
      frame_done_buf_o <= 1'b0;
      frame_err_o      <= 1'b0;
      drop_cnt_o       <= 8'd0;
    end else begin
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
      // Set wins over a same-cycle release of the same buffer.
      buf_full_o   <= (buf_full_o & ~buf_rel_i) | buf_set;
      case (state)
        S_IDLE: begin
          cap_en_o <= 1'b0;
          if (cfg_start_i && cfg_frame_pxl_i != '0) state <= S_WAIT_SOF;
        end
        S_WAIT_SOF: begin
          if (!cfg_start_i) begin
            state <= S_IDLE;
          end else if (sof_i) begin
            if (pick_ok) begin
              buf_sel_o       <= pick_buf;
              pxl_base_addr_o <= pick_buf ? cfg_buf1_base_i : cfg_buf0_base_i;
              frame_size      <= cfg_frame_pxl_i;
              pxl_cnt         <= '0;
              cap_en_o        <= 1'b1;
              state           <= S_CAPTURE;
            end else if (drop_cnt_o != 8'hFF) begin
              drop_cnt_o <= drop_cnt_o + 8'd1;
            end
          end
        end
        S_CAPTURE: begin
          // Completion has priority over both abort and short-frame restart.
          if (last_pxl) begin
            cap_en_o <= 1'b0;
            state    <= S_DRAIN;
          end else if (!cfg_start_i) begin
            cap_en_o <= 1'b0;
            state    <= S_ABORT;
          end else if (sof_i) begin
            frame_err_o <= 1'b1;
            pxl_cnt     <= '0;
          end else if (pxl_acc_i) begin
            pxl_cnt <= pxl_cnt + PXL_CNT_W'(1);
          end
        end
        S_DRAIN: begin
          cap_en_o <= 1'b0;
          if (wr_idle_i) begin
            frame_done_o     <= 1'b1;
            frame_done_buf_o <= buf_sel_o;
            next_buf         <= ~buf_sel_o;
            state            <= (cfg_single_i || !cfg_start_i) ? S_IDLE : S_WAIT_SOF;
          end
        end
        S_ABORT: begin
          cap_en_o <= 1'b0;
          if (wr_idle_i) state <= S_IDLE;
        end
        default: begin
          cap_en_o <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dvp_frame_scheduler.sv
// Randomized bench for dvp_frame_scheduler against a frame-level ownership model.
module tb_dvp_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, single, sof, acc, idle;
  logic [19:0] fpx;
  logic [31:0] b0, b1;
  logic [1:0]  rel;
  logic        cap_en, buf_sel, done, done_buf, err;
  logic [31:0] base;
  logic [1:0]  full;
  logic [7:0]  drop;
  logic [2:0]  state;

  int n_chk  = 0;
  int n_fail = 0;

  // Frame-level reference: buffer ownership, ping-pong preference, drop count.
  logic [1:0] m_full;
  logic       m_next;
  int         m_drop;

  dvp_frame_scheduler #(.ADDR_W(32), .PXL_CNT_W(20)) dut (
    .clk(clk), .rst(rst),
    .cfg_start_i(start), .cfg_single_i(single), .cfg_frame_pxl_i(fpx),
    .cfg_buf0_base_i(b0), .cfg_buf1_base_i(b1),
    .sof_i(sof), .pxl_acc_i(acc), .wr_idle_i(idle), .buf_rel_i(rel),
    .cap_en_o(cap_en), .pxl_base_addr_o(base), .buf_sel_o(buf_sel),
    .buf_full_o(full), .frame_done_o(done), .frame_done_buf_o(done_buf),
    .frame_err_o(err), .drop_cnt_o(drop), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sof = 1'b0;
    acc = 1'b0;
    rel = 2'b00;
  endtask

  function automatic bit model_pick(output logic b);
    b = m_next;
    if (!m_full[m_next])  return 1'b1;
    b = ~m_next;
    if (!m_full[~m_next]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_full = 2'b00;
    m_next = 1'b0;
    m_drop = 0;
  endtask

  // Start a capture on SOF; returns the buffer the model expects.
  task automatic start_frame(output logic b, output int sz);
    logic [31:0] exp_base;
    if (!model_pick(b)) check("pick_expected", 1, 0);
    exp_base = b ? b1 : b0;
    sz = int'(fpx);
    sof = 1'b1;
    step();
    check("cap_en_on", cap_en, 1);
    check("buf_sel", buf_sel, b);
    check("base_addr", base, exp_base);
    check("state_capture", state, 2);
  endtask

  task automatic feed(input int n_pix);
    int n = 0;
    while (n < n_pix) begin
      acc = ($urandom_range(0, 3) != 0);
      if (acc) n++;
      step();
      if (n < n_pix) check("cap_hold", cap_en, 1);
    end
  endtask

  task automatic finish_frame(input logic b, input bit rel_same, input bit release_after);
    int w;
    check("drain_state", state, 3);
    check("cap_en_off", cap_en, 0);
    idle = 1'b0;
    w = $urandom_range(0, 3);
    repeat (w) begin
      acc = $urandom_range(0, 1);
      step();
      check("no_early_done", done, 0);
      check("drain_hold", state, 3);
    end
    idle = 1'b1;
    if (rel_same) rel[b] = 1'b1;
    step();
    m_full[b] = 1'b1;
    m_next    = ~b;
    check("frame_done", done, 1);
    check("frame_done_buf", done_buf, b);
    check("buf_full_set", full, m_full);
    check("post_done_state", state, (single || !start) ? 3'd0 : 3'd1);
    idle = 1'b0;
    if (release_after) begin
      rel[b] = 1'b1;
      step();
      m_full[b] = 1'b0;
      check("buf_released", full, m_full);
      check("done_single_pulse", done, 0);
    end
  endtask

  task automatic do_frame(input bit release_after, input bit mid_change);
    logic b;
    int   sz;
    start_frame(b, sz);
    if (mid_change) begin
      fpx = 20'($urandom_range(4, 40));
      b0  = $urandom;
      b1  = $urandom;
    end
    feed(sz);
    finish_frame(b, $urandom_range(0, 1), release_after);
  endtask

  task automatic do_drop();
    sof = 1'b1;
    step();
    if (m_drop < 255) m_drop++;
    check("drop_no_cap", cap_en, 0);
    check("drop_state", state, 1);
    check("drop_cnt", drop, m_drop);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_cap_en"}, cap_en, 0);
    check({pfx, "_base"}, base, 0);
    check({pfx, "_buf_sel"}, buf_sel, 0);
    check({pfx, "_full"}, full, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_done_buf"}, done_buf, 0);
    check({pfx, "_err"}, err, 0);
    check({pfx, "_drop"}, drop, 0);
    check({pfx, "_state"}, state, 0);
  endtask

  initial begin
    logic b;
    int   sz;
    rst = 1'b1; start = 1'b0; single = 1'b0; sof = 1'b0; acc = 1'b0;
    idle = 1'b0; rel = 2'b00; fpx = 20'd16; b0 = 32'h1000; b1 = 32'h2000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Zero frame size keeps the block idle even when started.
    start = 1'b1; fpx = 20'd0;
    step();
    check("idle_zero_size", state, 0);
    fpx = 20'd16;
    step();
    check("arm_wait_sof", state, 1);

    // Continuous capture with releases: buffers 0,1,0 at 0x1000,0x2000,0x1000.
    repeat (3) do_frame(1'b1, 1'b0);
    // Random sizes/bases changed mid-frame take effect next frame only.
    repeat (4) do_frame(1'b1, 1'b1);
    fpx = 20'd16; b0 = 32'h1000; b1 = 32'h2000;

    // No releases: fill both, then drop.
    do_frame(1'b0, 1'b0);
    do_frame(1'b0, 1'b0);
    do_drop();
    do_drop();
    check("both_full", full, 2'b11);
    rel = 2'b10;
    step();
    m_full[1] = 1'b0;
    check("rel_buf1", full, m_full);
    start_frame(b, sz);
    check("refill_buf1", b, 1);
    feed(sz);
    finish_frame(b, 1'b0, 1'b0);
    rel = 2'b11;
    step();
    m_full = 2'b00;
    check("rel_all", full, 2'b00);

    // Short frame: SOF after 10 of 16 pixels, then a completing frame whose
    // last pixel coincides with SOF.
    start_frame(b, sz);
    repeat (10) begin acc = 1'b1; step(); end
    sof = 1'b1;
    step();
    check("short_err", err, 1);
    check("short_state", state, 2);
    check("short_same_buf", buf_sel, b);
    check("short_cap_en", cap_en, 1);
    step();
    check("err_single_pulse", err, 0);
    repeat (15) begin acc = 1'b1; step(); end
    check("restart_hold", state, 2);
    acc = 1'b1; sof = 1'b1;
    step();
    check("last_beats_sof", err, 0);
    finish_frame(b, 1'b0, 1'b1);

    // Single-shot mode.
    single = 1'b1;
    do_frame(1'b1, 1'b0);
    start = 1'b0;
    step();
    check("single_idle", state, 0);
    sof = 1'b1;
    step();
    check("single_no_cap", cap_en, 0);
    check("single_stay_idle", state, 0);
    step();
    check("single_no_done", done, 0);

    // Abort after 5 pixels with the writer busy for 3 cycles.
    single = 1'b0; start = 1'b1;
    step();
    check("abort_arm", state, 1);
    start_frame(b, sz);
    repeat (5) begin acc = 1'b1; step(); end
    start = 1'b0; idle = 1'b0;
    step();
    check("abort_state", state, 4);
    check("abort_cap_off", cap_en, 0);
    repeat (3) begin
      step();
      check("abort_hold", state, 4);
      check("abort_no_done", done, 0);
    end
    idle = 1'b1;
    step();
    check("abort_idle", state, 0);
    check("abort_no_done2", done, 0);
    check("abort_full_same", full, m_full);
    idle = 1'b0;

    // Asynchronous reset mid-capture with non-zero history.
    start = 1'b1;
    step();
    do_frame(1'b0, 1'b0);
    start_frame(b, sz);
    repeat (3) begin acc = 1'b1; step(); end
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step();

    // Drop counter saturation.
    start = 1'b1; fpx = 20'd8;
    step();
    do_frame(1'b0, 1'b0);
    do_frame(1'b0, 1'b0);
    repeat (300) do_drop();
    check("drop_saturated", drop, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
